// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The fetch stage uses the master modport, the memory (or its model) the slave.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;

    // imem_req is taken by the memory in the cycle it is high; imem_valid/imem_rdata
    // return the word no earlier than the following cycle, one request outstanding.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, one-outstanding imem requests, one-word hold buffer, IF/ID register.
// Optional FETCH_STATS_EN adds saturating stat_fetched / stat_wait counters.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic [15:0]   PC_next,
    fetch_stage_if.master imem,
    output logic [15:0]   instr,
    output logic [15:0]   currPC,
    output logic [15:0]   new_addr,
    output logic          if_valid,
    output logic [1:0]    o_dbg_state
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]   stat_fetched,
    output logic [15:0]   stat_wait
`else
    // statistics ports not built
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_pc;
    logic [15:0] r_fly_pc;
    logic [15:0] r_hold_instr;
    logic [15:0] r_hold_pc;
    logic        r_hold_valid;
    logic [15:0] r_instr;
    logic [15:0] r_curr_pc;
    logic [15:0] r_new_addr;
    logic        r_if_valid;

    logic        w_req;
    logic        w_take;
    logic        w_buffer;
    logic        w_drain;
    logic        w_rdata_halt;
    logic        w_hold_halt;

    assign w_rdata_halt = (imem.imem_rdata[15:11] == 5'b00000);
    assign w_hold_halt  = (r_hold_instr[15:11] == 5'b00000);
    assign w_drain      = r_hold_valid && !stall && !flush;
    assign w_take       = (r_state == S_WAIT) && imem.imem_valid && !stall && !flush;
    assign w_buffer     = (r_state == S_WAIT) && imem.imem_valid && stall && !flush;

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else if (w_drain) begin
                    w_next_state = w_hold_halt ? S_HALTED : S_IDLE;
                end else if (!r_hold_valid) begin
                    w_req        = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // A flush with the word already on the bus drops it; otherwise it is still owed.
                if (flush) begin
                    w_next_state = imem.imem_valid ? S_IDLE : S_DISCARD;
                end else if (imem.imem_valid) begin
                    if (stall) begin
                        w_next_state = S_IDLE;
                    end else if (w_rdata_halt) begin
                        w_next_state = S_HALTED;
                    end else begin
                        w_req = 1'b1;
                    end
                end
            end
            S_DISCARD: begin
                if (!flush && imem.imem_valid) begin
                    w_next_state = S_IDLE;
                end
            end
            S_HALTED: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign imem.imem_req  = w_req && !rst;
    assign imem.imem_addr = r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_fly_pc     <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc    <= 16'h0000;
            r_hold_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (flush) begin
                r_pc <= PC_next;
            end else if (w_req) begin
                r_fly_pc <= r_pc;
                r_pc     <= r_pc + 16'd2;
            end
            if (flush) begin
                r_hold_valid <= 1'b0;
            end else if (w_buffer) begin
                r_hold_instr <= imem.imem_rdata;
                r_hold_pc    <= r_fly_pc;
                r_hold_valid <= 1'b1;
            end else if (w_drain) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // IF/ID: a bubble keeps currPC/new_addr; the hold buffer outranks fresh memory data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr    <= NOP_INSTR;
            r_curr_pc  <= 16'h0000;
            r_new_addr <= 16'h0000;
            r_if_valid <= 1'b0;
        end else if (flush) begin
            r_instr    <= NOP_INSTR;
            r_if_valid <= 1'b0;
        end else if (!stall) begin
            if (r_hold_valid) begin
                r_instr    <= r_hold_instr;
                r_curr_pc  <= r_hold_pc;
                r_new_addr <= r_hold_pc + 16'd2;
                r_if_valid <= 1'b1;
            end else if (w_take) begin
                r_instr    <= imem.imem_rdata;
                r_curr_pc  <= r_fly_pc;
                r_new_addr <= r_fly_pc + 16'd2;
                r_if_valid <= 1'b1;
            end else begin
                r_instr    <= NOP_INSTR;
                r_if_valid <= 1'b0;
            end
        end
    end

    assign instr       = r_instr;
    assign currPC      = r_curr_pc;
    assign new_addr    = r_new_addr;
    assign if_valid    = r_if_valid;
    assign o_dbg_state = r_state;

`ifdef FETCH_STATS_EN
    logic [15:0] r_stat_fetched;
    logic [15:0] r_stat_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_fetched <= 16'h0000;
            r_stat_wait    <= 16'h0000;
        end else begin
            if ((w_drain || w_take) && (r_stat_fetched != 16'hFFFF)) begin
                r_stat_fetched <= r_stat_fetched + 16'd1;
            end
            if ((((r_state == S_WAIT) && !imem.imem_valid) || (r_state == S_DISCARD)) &&
                (r_stat_wait != 16'hFFFF)) begin
                r_stat_wait <= r_stat_wait + 16'd1;
            end
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_wait    = r_stat_wait;
`else
    // statistics counters not built
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable imem model feeding a scoreboard of IF/ID words,
// plus cycle-by-cycle request/redirect checks.
module tb_fetch_stage;
  localparam logic [15:0] NOP       = 16'h0800;
  localparam logic [15:0] HALT_ADDR = 16'h0010;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] pc_next;
  logic [15:0] instr;
  logic [15:0] curr_pc;
  logic [15:0] new_addr;
  logic        if_valid;
  logic [1:0]  dbg_state;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched;
  logic [15:0] stat_wait;
`endif

  fetch_stage_if mif();

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .PC_next     (pc_next),
    .imem        (mif),
    .instr       (instr),
    .currPC      (curr_pc),
    .new_addr    (new_addr),
    .if_valid    (if_valid),
    .o_dbg_state (dbg_state)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_wait   (stat_wait)
`endif
  );

  int          n_tests;
  int          n_fail;
  int          mem_lat;
  logic [47:0] exp_q[$];
  logic        last_stall;
  logic [15:0] last_exp_instr;

  // clock / reset-free clock generator
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] k;
    if (a == HALT_ADDR) return 16'h0000;
    k = (a >> 1) + 16'd1;
    return 16'h4000 | (k & 16'h0FFF);
  endfunction

  // driver: one cycle, inputs changed just after the edge, then wait to the sample point
  task automatic step(input logic s, input logic f, input logic [15:0] pcn);
    @(posedge clk);
    #1;
    stall   = s;
    flush   = f;
    pc_next = pcn;
    @(negedge clk);
  endtask

  task automatic check_req(input string tag, input logic req, input logic [15:0] addr);
    check_eq({tag, "_req"}, mif.imem_req, req);
    if (req) check_eq({tag, "_addr"}, mif.imem_addr, addr);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req"}, mif.imem_req, 1'b0);
    check_eq({tag, "_instr"}, instr, NOP);
    check_eq({tag, "_ifv"}, if_valid, 1'b0);
    check_eq({tag, "_pc"}, curr_pc, 16'h0000);
    check_eq({tag, "_new"}, new_addr, 16'h0000);
    check_eq({tag, "_state"}, dbg_state, 2'd0);
`ifdef FETCH_STATS_EN
    check_eq({tag, "_sfetch"}, stat_fetched, 16'h0000);
    check_eq({tag, "_swait"}, stat_wait, 16'h0000);
`endif
  endtask

  // imem model: accepts at the sample point, answers mem_lat cycles later, feeds the scoreboard
  initial begin
    logic        pend;
    logic        stale;
    logic        acc;
    logic [15:0] acc_addr;
    logic [15:0] p_addr;
    logic [15:0] d_addr;
    int          cnt;
    pend = 1'b0; stale = 1'b0; acc = 1'b0; acc_addr = '0; p_addr = '0; d_addr = '0; cnt = 0;
    mif.imem_valid = 1'b0;
    mif.imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      acc      = mif.imem_req && !rst;
      acc_addr = mif.imem_addr;
      if (mif.imem_valid && !flush && !stale && !rst)
        exp_q.push_back({mif.imem_rdata, d_addr, d_addr + 16'd2});
      if (mif.imem_valid) stale = 1'b0;
      else if (flush && pend) stale = 1'b1;
      @(posedge clk);
      #1;
      mif.imem_valid = 1'b0;
      if (rst) begin
        pend  = 1'b0;
        stale = 1'b0;
      end else begin
        if (acc) begin
          pend   = 1'b1;
          p_addr = acc_addr;
          cnt    = mem_lat;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mif.imem_valid = 1'b1;
            mif.imem_rdata = mem_word(p_addr);
            d_addr         = p_addr;
            pend           = 1'b0;
          end
        end
      end
    end
  end

  // scoreboard: a fresh IF/ID word appears after every cycle decode was not stalled
  initial begin
    logic [47:0] e;
    last_stall     = 1'b0;
    last_exp_instr = NOP;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if_valid && !last_stall) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_extra", {instr, curr_pc, new_addr}, 48'h0);
          end else begin
            e = exp_q.pop_front();
            check_eq("sb_ifid", {instr, curr_pc, new_addr}, e);
            last_exp_instr = e[47:32];
          end
        end else if (if_valid) begin
          check_eq("ifid_hold", instr, last_exp_instr);
        end else begin
          check_eq("bubble", instr, NOP);
        end
      end
      last_stall = stall;
    end
  end

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; pc_next = 16'h0000; mem_lat = 1;
    #2 rst = 1'b1;
    #1 check_reset("rst0");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_req("c0", 1'b1, 16'h0000);
    step(0, 0, 0); check_req("c1", 1'b1, 16'h0002);
    step(0, 0, 0); check_req("c2", 1'b1, 16'h0004);
    check_eq("first_instr", instr, 16'h4001);
    check_eq("first_pc", curr_pc, 16'h0000);
    check_eq("first_new", new_addr, 16'h0002);
    step(0, 0, 0); check_req("c3", 1'b1, 16'h0006);
    // three stalled cycles: one word parked, no further requests
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0); check_req("stall", 1'b0, 16'h0000);
    end
    step(0, 0, 0); check_req("drain", 1'b0, 16'h0000);
    step(0, 0, 0); check_req("c8", 1'b1, 16'h0008);
    step(0, 0, 0); check_req("c9", 1'b1, 16'h000A);
    mem_lat = 3;
    step(0, 0, 0); check_req("c10", 1'b0, 16'h0000);
    step(0, 1, 16'h0100); check_req("flush_wait", 1'b0, 16'h0000);
    step(0, 0, 0); check_req("discard", 1'b0, 16'h0000);
    check_eq("fl_ifv", if_valid, 1'b0);
    check_eq("fl_instr", instr, NOP);
    check_eq("fl_pc_keep", curr_pc, 16'h0008);
    check_eq("fl_new_keep", new_addr, 16'h000A);
    mem_lat = 1;
    step(0, 0, 0); check_req("redirect", 1'b1, 16'h0100);
    step(1, 1, 16'h0200); check_req("flush_stall", 1'b0, 16'h0000);
    step(0, 0, 0); check_req("redirect2", 1'b1, 16'h0200);
    check_eq("fs_ifv", if_valid, 1'b0);
    step(0, 1, 16'h000C); check_req("flush3", 1'b0, 16'h0000);
    step(0, 0, 0); check_req("c17", 1'b1, 16'h000C);
    step(0, 0, 0); check_req("c18", 1'b1, 16'h000E);
    step(0, 0, 0); check_req("c19", 1'b1, 16'h0010);
    step(0, 0, 0); check_req("halt", 1'b0, 16'h0000);
    step(0, 0, 0); check_req("halted", 1'b0, 16'h0000);
    check_eq("halt_instr", instr, 16'h0000);
    check_eq("halt_pc", curr_pc, HALT_ADDR);
    check_eq("halt_ifv", if_valid, 1'b1);
    check_eq("halt_state", dbg_state, 2'd3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0); check_req("halted_n", 1'b0, 16'h0000);
    end
    step(0, 1, 16'h0020); check_req("unhalt", 1'b0, 16'h0000);
    step(0, 0, 0); check_req("resume", 1'b1, 16'h0020);
    step(0, 1, 16'hFFFE); check_req("flush_wrap", 1'b0, 16'h0000);
    step(0, 0, 0); check_req("top", 1'b1, 16'hFFFE);
    step(0, 0, 0); check_req("wrap", 1'b1, 16'h0000);
    step(0, 0, 0);
    check_eq("wrap_pc", curr_pc, 16'hFFFE);
    check_eq("wrap_new", new_addr, 16'h0000);
    check_eq("wrap_instr", instr, 16'h4000);
    step(0, 1, 16'h0010);
    step(0, 0, 0); check_req("c32", 1'b1, 16'h0010);
    step(0, 0, 0); check_req("halt2", 1'b0, 16'h0000);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check_eq("sb_drain", exp_q.size(), 0);
    // asynchronous reset mid-run, then slow memory
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset("rst1");
    mem_lat = 3;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); check_req("r0", 1'b1, 16'h0000);
    step(0, 0, 0); check_req("r1", 1'b0, 16'h0000);
    step(0, 0, 0);
    step(0, 0, 0); check_req("r3", 1'b1, 16'h0002);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0); check_req("r6", 1'b1, 16'h0004);
    step(0, 0, 0);
    check_eq("slow_pc", curr_pc, 16'h0002);
`ifdef FETCH_STATS_EN
    check_eq("stat_fetched", stat_fetched, 16'd2);
    check_eq("stat_wait", stat_wait, 16'd4);
`endif
    step(0, 0, 0);
    step(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage feeding the decode stage. Holds the PC, issues one-outstanding requests to the instruction memory, and registers the fetched word with its PC and PC+2 into the IF/ID pipeline register. Redirects come from decode (flush with target PC). Stops fetching after a HALT word.

## Interface
- RESET_PC, 16'h0000, PC fetched first after reset
- NOP_INSTR, 16'h0800, bubble word driven to decode when no valid instruction
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  decode cannot accept; IF/ID must hold
- flush  in  1  redirect from decode; higher priority than stall
- PC_next  in  16  redirect target, sampled when flush=1
- imem_req  out  1  fetch request; accepted in the cycle it is high
- imem_addr  out  16  word address of request, valid when imem_req=1
- imem_valid  in  1  read data returned; never earlier than the cycle after acceptance
- imem_rdata  in  16  instruction word, valid with imem_valid
- instr  out  16  IF/ID instruction (NOP_INSTR when if_valid=0)
- currPC  out  16  address of instr
- new_addr  out  16  currPC+2
- if_valid  out  1  IF/ID holds a real instruction

## Operation
- Registers: pc (next address to request), fly_pc (address of outstanding request), hold buffer (1 word + PC + valid flag), IF/ID (instr, currPC, new_addr, if_valid), 2-bit state.
- States: IDLE, WAIT, DISCARD, HALTED.
- IDLE: imem_req=1, imem_addr=pc; fly_pc<=pc, pc<=pc+2 (16-bit wrap, 0xFFFE+2=0x0000); -> WAIT. Suppressed (req=0) while hold buffer full.
- WAIT, imem_valid=1, stall=0: word to IF/ID, if_valid=1. If word[15:11]==5'b00000 (HALT) -> HALTED, no request; else request next pc in same cycle, remain WAIT.
- WAIT, imem_valid=1, stall=1: word into hold buffer, IF/ID unchanged; -> IDLE (req blocked until buffer drains). HALT word in buffer -> HALTED after drain.
- Hold buffer drains into IF/ID on the first cycle with stall=0; buffer has priority over new fetch data.
- Stall with empty buffer: IF/ID unchanged, fetching continues until buffer fills.
- flush=1 (any state): pc<=PC_next, hold buffer cleared, IF/ID<=NOP_INSTR/if_valid=0; currPC/new_addr retain. From WAIT with imem_valid=0 -> DISCARD; otherwise (incl. imem_valid=1 same cycle, data dropped) -> IDLE. From HALTED -> IDLE (HALT was wrong-path).
- DISCARD: req=0; on imem_valid drop data -> IDLE. flush in DISCARD updates pc, stays DISCARD.
- HALTED: req=0, IF/ID drains normally, then if_valid=0; stays until flush or rst.
- stall=1 and flush=1 together: flush wins.

## Timing
- Reset (async): state=IDLE, pc=RESET_PC, hold empty, instr=NOP_INSTR, if_valid=0, currPC=0, new_addr=0, imem_req drops immediately with rst.
- First request on first clock edge after rst deasserts.
- Latency: imem_valid in cycle N -> instr visible cycle N+1.
- 1-cycle memory, no stall: one instruction per cycle.
- imem_req/imem_addr are combinational from state, pc, imem_valid, stall, flush; imem_req=0 in any cycle flush=1.
- Max one outstanding request; imem_valid outside WAIT/DISCARD is ignored.

## Configuration
- FETCH_STATS_EN defined: adds outputs stat_fetched (16, instructions written into IF/ID with if_valid=1) and stat_wait (16, cycles in WAIT with imem_valid=0 or in DISCARD); both saturate at 16'hFFFF, reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, 1-cycle memory returning 0x4001,0x4002,0x4003 -> imem_addr 0x0000,0x0002,0x0004 on consecutive cycles; instr/currPC/new_addr = 0x4001/0x0000/0x0002 one cycle after first valid.
- stall=1 for 3 cycles mid-stream -> IF/ID frozen, exactly one word buffered, no further req; after release the buffered word appears next cycle, no word lost or duplicated.
- flush with PC_next=0x0100 while WAIT (valid late) -> IF/ID bubble 0x0800, returned stale word dropped, next imem_addr=0x0100.
- flush and imem_valid in same cycle -> word dropped, imem_addr=PC_next next cycle; flush+stall together -> flush behaviour.
- Fetch 0x0000 (HALT) at 0x0010 -> delivered to IF/ID, imem_req stays 0; later flush to 0x0020 resumes at 0x0020.
- pc=0xFFFE fetch -> new_addr=0x0000, next request 0x0000; with FETCH_STATS_EN, 3-cycle memory latency for 2 words -> stat_wait=4, stat_fetched=2.
